n64_cfg_exec: RTL and testbench
===============================

N64_CFG_EXEC -- requirements
Module: n64_cfg_exec

Interface
REQ-001 SHALL have parameter VERSION, default 32'h5343_7632, value returned by the version command.
REQ-002 SHALL have parameter NUM_REGS, default 8, number of 32-bit config registers (2..16).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cfg_pending  input  1  command posted by N64 side; held high until cfg_done is seen.
REQ-006 SHALL have port cfg_cmd  input  8  command code, valid while cfg_pending.
REQ-007 SHALL have ports cfg_rdata_0, cfg_rdata_1  input  32 each  command arguments from N64.
REQ-008 SHALL have port cfg_done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port cfg_error  output  1  error status of last command, held until next completion.
REQ-010 SHALL have ports cfg_wdata_0, cfg_wdata_1  output  32 each  result words, held until next completion.
REQ-011 SHALL have port cfg_irq  output  1  one-cycle interrupt pulse toward N64 side.
REQ-012 SHALL have port cfg_regs  output  NUM_REGS*32  packed config register file, entry i at [i*32+:32].
REQ-013 SHALL have ports cpu_req (output 1), cpu_cmd (output 8), cpu_arg_0/cpu_arg_1 (output 32): forward request to controller CPU.
REQ-014 SHALL have ports cpu_ack (input 1), cpu_error (input 1), cpu_result_0/cpu_result_1 (input 32): CPU completion, results valid with cpu_ack.
REQ-015 SHALL have port cpu_irq_req  input  1  CPU request to interrupt N64.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC, FORWARD, DONE, HOLD.
REQ-017 IDLE: on cfg_pending=1, latch cfg_cmd, cfg_rdata_0, cfg_rdata_1 and go to EXEC; else stay.
REQ-018 EXEC: cmd 8'h76 ('v') -> wdata_0=VERSION, wdata_1=0, error=0, go DONE.
REQ-019 EXEC: cmd 8'h63 ('c', get) -> idx=arg_0; idx<NUM_REGS: wdata_1=cfg_regs[idx], error=0; else wdata_1=0, error=1; wdata_0=arg_0; go DONE.
REQ-020 EXEC: cmd 8'h43 ('C', set) -> idx<NUM_REGS: wdata_1=old value, cfg_regs[idx]=arg_1 on the same edge, error=0; else no register change, error=1; wdata_0=arg_0; go DONE.
REQ-021 Index comparison SHALL use all 32 bits of arg_0 (e.g. 32'h0000_0100 is out of range).
REQ-022 EXEC: any other cmd -> assert cpu_req with cpu_cmd/cpu_arg_* = latched values, go FORWARD.
REQ-023 FORWARD: cpu_req, cpu_cmd, cpu_arg_* held stable until cpu_ack=1; on cpu_ack: deassert cpu_req, wdata_0/1=cpu_result_0/1, error=cpu_error, go DONE.
REQ-024 cpu_ack outside FORWARD SHALL be ignored.
REQ-025 DONE: cfg_done=1 for exactly this cycle; go HOLD.
REQ-026 HOLD: one cycle, cfg_pending ignored (lets N64 side clear pending); go IDLE.
REQ-027 Latency: cfg_pending first seen high in cycle N -> cfg_done high in cycle N+2 for local commands.
REQ-028 cfg_pending high again in IDLE after HOLD SHALL be treated as a new command (back-to-back supported).
REQ-029 cfg_wdata_*, cfg_error SHALL change only on transition into DONE.
REQ-030 cfg_irq SHALL be registered: cpu_irq_req high in cycle N -> cfg_irq high in cycle N+1, independent of FSM state.
REQ-031 cpu_irq_req held high K cycles SHALL produce K consecutive cfg_irq cycles.

Reset
REQ-032 Reset SHALL force state IDLE, cfg_done=0, cfg_error=0, cfg_wdata_*=0, cfg_irq=0, cpu_req=0, cpu_cmd=0, cpu_arg_*=0, cfg_regs all zero.
REQ-033 Reset asserted mid-FORWARD SHALL drop cpu_req immediately (asynchronously); no cfg_done issued for the aborted command.
REQ-034 After reset release, first rising edge with cfg_pending=1 SHALL start a command normally.

Verification
REQ-035 Version: pending with cmd 8'h76 -> cfg_done at N+2, wdata_0=32'h5343_7632, error=0.
REQ-036 Set/get: 'C' arg_0=3 arg_1=32'hDEAD_BEEF -> wdata_1=0, cfg_regs[3]=32'hDEAD_BEEF; then 'c' arg_0=3 -> wdata_1=32'hDEAD_BEEF.
REQ-037 Out of range: 'C' arg_0=8 arg_1=1 -> error=1, cfg_regs unchanged; 'c' arg_0=32'hFFFF_FFFF -> error=1, wdata_1=0.
REQ-038 Forward: cmd 8'h55 -> cpu_req=1, cpu_cmd=8'h55; cpu_ack after 10 cycles with result_0=32'h1234, error=1 -> single cfg_done, wdata_0=32'h1234, error=1.
REQ-039 Back-to-back: pending re-asserted in HOLD's following cycle -> second command executes, exactly one cfg_done per command.
REQ-040 Reset mid-FORWARD: cpu_req falls with reset, no cfg_done; cpu_irq_req 1-cycle pulse -> exactly one cfg_irq cycle.

Source files
------------

// File: rtl/n64_cfg_exec.sv
// n64_cfg_exec: executes configuration commands posted by the N64 side.
// Version, register get and register set are handled locally. Any other
// command code is forwarded to the controller CPU and its results are returned.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   cfg_pending/cfg_cmd/cfg_rdata_* posted command and its two argument words
//   cfg_done                        one-cycle completion pulse
//   cfg_error/cfg_wdata_*           status and result words of the last command
//   cfg_irq                         registered copy of cpu_irq_req
//   cfg_regs                        packed register file, entry i at [i*32+:32]
//   cpu_req/cpu_cmd/cpu_arg_*       request forwarded to the controller CPU
//   cpu_ack/cpu_error/cpu_result_*  CPU completion (results valid with cpu_ack)
//   cpu_irq_req                     CPU request to interrupt the N64 side
module n64_cfg_exec #(
  parameter logic [31:0] VERSION  = 32'h5343_7632,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_pending,
  input  logic [7:0]               cfg_cmd,
  input  logic [31:0]              cfg_rdata_0,
  input  logic [31:0]              cfg_rdata_1,
  output logic                     cfg_done,
  output logic                     cfg_error,
  output logic [31:0]              cfg_wdata_0,
  output logic [31:0]              cfg_wdata_1,
  output logic                     cfg_irq,
  output logic [NUM_REGS*32-1:0]   cfg_regs,
  output logic                     cpu_req,
  output logic [7:0]               cpu_cmd,
  output logic [31:0]              cpu_arg_0,
  output logic [31:0]              cpu_arg_1,
  input  logic                     cpu_ack,
  input  logic                     cpu_error,
  input  logic [31:0]              cpu_result_0,
  input  logic [31:0]              cpu_result_1,
  input  logic                     cpu_irq_req
);

  localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0]  CMD_VER = 8'h76;
  localparam logic [7:0]  CMD_GET = 8'h63;
  localparam logic [7:0]  CMD_SET = 8'h43;

  typedef enum logic [2:0] {IDLE, EXEC, FORWARD, DONE, HOLD} state_t;

  state_t                  state, state_d;
  logic [7:0]              cmd_q, cmd_d;
  logic [31:0]             arg0_q, arg0_d;
  logic [31:0]             arg1_q, arg1_d;
  logic                    done_d, error_d;
  logic [31:0]             wdata0_d, wdata1_d;
  logic [NUM_REGS*32-1:0]  regs_d;
  logic                    req_d;
  logic [7:0]              ccmd_d;
  logic [31:0]             carg0_d, carg1_d;

  logic [IDX_W-1:0]        idx;
  logic [IDX_W+4:0]        base;
  logic                    idx_ok;

  // Range check uses the full 32-bit argument; the narrow index is only
  // used for the part-select once the check has passed.
  assign idx    = arg0_q[IDX_W-1:0];
  assign base   = {idx, 5'd0};
  assign idx_ok = (arg0_q < 32'(NUM_REGS));

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state;
    cmd_d    = cmd_q;
    arg0_d   = arg0_q;
    arg1_d   = arg1_q;
    done_d   = 1'b0;
    error_d  = cfg_error;
    wdata0_d = cfg_wdata_0;
    wdata1_d = cfg_wdata_1;
    regs_d   = cfg_regs;
    req_d    = cpu_req;
    ccmd_d   = cpu_cmd;
    carg0_d  = cpu_arg_0;
    carg1_d  = cpu_arg_1;

    case (state)
      IDLE: begin
        if (cfg_pending) begin
          cmd_d   = cfg_cmd;
          arg0_d  = cfg_rdata_0;
          arg1_d  = cfg_rdata_1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (cmd_q)
          CMD_VER: begin
            wdata0_d = VERSION;
            wdata1_d = 32'd0;
            error_d  = 1'b0;
            done_d   = 1'b1;
            state_d  = DONE;
          end
          CMD_GET: begin
            wdata0_d = arg0_q;
            if (idx_ok) begin
              wdata1_d = cfg_regs[base +: 32];
              error_d  = 1'b0;
            end else begin
              wdata1_d = 32'd0;
              error_d  = 1'b1;
            end
            done_d  = 1'b1;
            state_d = DONE;
          end
          CMD_SET: begin
            wdata0_d = arg0_q;
            if (idx_ok) begin
              wdata1_d           = cfg_regs[base +: 32];
              regs_d[base +: 32] = arg1_q;
              error_d            = 1'b0;
            end else begin
              wdata1_d = 32'd0;
              error_d  = 1'b1;
            end
            done_d  = 1'b1;
            state_d = DONE;
          end
          default: begin
            req_d   = 1'b1;
            ccmd_d  = cmd_q;
            carg0_d = arg0_q;
            carg1_d = arg1_q;
            state_d = FORWARD;
          end
        endcase
      end
      FORWARD: begin
        if (cpu_ack) begin
          req_d    = 1'b0;
          wdata0_d = cpu_result_0;
          wdata1_d = cpu_result_1;
          error_d  = cpu_error;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cmd_q       <= 8'd0;
      arg0_q      <= 32'd0;
      arg1_q      <= 32'd0;
      cfg_done    <= 1'b0;
      cfg_error   <= 1'b0;
      cfg_wdata_0 <= 32'd0;
      cfg_wdata_1 <= 32'd0;
      cfg_regs    <= '0;
      cpu_req     <= 1'b0;
      cpu_cmd     <= 8'd0;
      cpu_arg_0   <= 32'd0;
      cpu_arg_1   <= 32'd0;
    end else begin
      state       <= state_d;
      cmd_q       <= cmd_d;
      arg0_q      <= arg0_d;
      arg1_q      <= arg1_d;
      cfg_done    <= done_d;
      cfg_error   <= error_d;
      cfg_wdata_0 <= wdata0_d;
      cfg_wdata_1 <= wdata1_d;
      cfg_regs    <= regs_d;
      cpu_req     <= req_d;
      cpu_cmd     <= ccmd_d;
      cpu_arg_0   <= carg0_d;
      cpu_arg_1   <= carg1_d;
    end
  end

  // Interrupt is a one-cycle-delayed copy of the CPU request, state independent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cfg_irq <= 1'b0;
    else       cfg_irq <= cpu_irq_req;
  end

endmodule

// File: tb/tb_n64_cfg_exec.sv
// tb_n64_cfg_exec: directed test of n64_cfg_exec with immediate-assertion checks.
module tb_n64_cfg_exec;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_pending;
  logic [7:0]   cfg_cmd;
  logic [31:0]  cfg_rdata_0, cfg_rdata_1;
  logic         cfg_done, cfg_error, cfg_irq;
  logic [31:0]  cfg_wdata_0, cfg_wdata_1;
  logic [255:0] cfg_regs;
  logic         cpu_req;
  logic [7:0]   cpu_cmd;
  logic [31:0]  cpu_arg_0, cpu_arg_1;
  logic         cpu_ack, cpu_error;
  logic [31:0]  cpu_result_0, cpu_result_1;
  logic         cpu_irq_req;

  int total = 0;
  int bad   = 0;
  int dones;
  logic [255:0] exp_regs;

  n64_cfg_exec #(.VERSION(32'h5343_7632), .NUM_REGS(8)) dut (
    .clk(clk), .reset(reset),
    .cfg_pending(cfg_pending), .cfg_cmd(cfg_cmd),
    .cfg_rdata_0(cfg_rdata_0), .cfg_rdata_1(cfg_rdata_1),
    .cfg_done(cfg_done), .cfg_error(cfg_error),
    .cfg_wdata_0(cfg_wdata_0), .cfg_wdata_1(cfg_wdata_1),
    .cfg_irq(cfg_irq), .cfg_regs(cfg_regs),
    .cpu_req(cpu_req), .cpu_cmd(cpu_cmd),
    .cpu_arg_0(cpu_arg_0), .cpu_arg_1(cpu_arg_1),
    .cpu_ack(cpu_ack), .cpu_error(cpu_error),
    .cpu_result_0(cpu_result_0), .cpu_result_1(cpu_result_1),
    .cpu_irq_req(cpu_irq_req)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Post a local command and step through EXEC, DONE, HOLD back to IDLE.
  task automatic run_cmd(input string tag, input logic [7:0] c,
                         input logic [31:0] a0, input logic [31:0] a1);
    cfg_pending = 1'b1;
    cfg_cmd     = c;
    cfg_rdata_0 = a0;
    cfg_rdata_1 = a1;
    tick();
    chk({tag, "_done_n1"}, 256'(cfg_done), 256'(1'b0));
    tick();
    chk({tag, "_done_n2"}, 256'(cfg_done), 256'(1'b1));
    cfg_pending = 1'b0;
    tick();
    chk({tag, "_done_n3"}, 256'(cfg_done), 256'(1'b0));
    tick();
  endtask

  initial begin
    reset = 1'b1;
    cfg_pending = 1'b0; cfg_cmd = 8'd0; cfg_rdata_0 = 32'd0; cfg_rdata_1 = 32'd0;
    cpu_ack = 1'b0; cpu_error = 1'b0; cpu_result_0 = 32'd0; cpu_result_1 = 32'd0;
    cpu_irq_req = 1'b0;
    exp_regs = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_done",  256'(cfg_done), 256'(1'b0));
    chk("rst_error", 256'(cfg_error), 256'(1'b0));
    chk("rst_wdata", 256'({cfg_wdata_1, cfg_wdata_0}), 256'(64'd0));
    chk("rst_cpu",   256'({cpu_req, cpu_cmd, cpu_arg_0, cpu_arg_1}), 256'(73'd0));
    chk("rst_irq",   256'(cfg_irq), 256'(1'b0));
    chk("rst_regs",  cfg_regs, 256'd0);

    // Version
    run_cmd("ver", 8'h76, 32'h0, 32'h0);
    chk("ver_w0",  256'(cfg_wdata_0), 256'(32'h5343_7632));
    chk("ver_w1",  256'(cfg_wdata_1), 256'(32'h0));
    chk("ver_err", 256'(cfg_error), 256'(1'b0));

    // Set reg 3 then get it back
    run_cmd("set3", 8'h43, 32'd3, 32'hDEAD_BEEF);
    exp_regs[3*32 +: 32] = 32'hDEAD_BEEF;
    chk("set3_w0",   256'(cfg_wdata_0), 256'(32'd3));
    chk("set3_w1",   256'(cfg_wdata_1), 256'(32'd0));
    chk("set3_err",  256'(cfg_error), 256'(1'b0));
    chk("set3_regs", cfg_regs, exp_regs);
    run_cmd("get3", 8'h63, 32'd3, 32'h0);
    chk("get3_w1",  256'(cfg_wdata_1), 256'(32'hDEAD_BEEF));
    chk("get3_err", 256'(cfg_error), 256'(1'b0));

    // Top index and overwrite returning old value
    run_cmd("set7", 8'h43, 32'd7, 32'h0102_0304);
    exp_regs[7*32 +: 32] = 32'h0102_0304;
    chk("set7_regs", cfg_regs, exp_regs);
    run_cmd("set3b", 8'h43, 32'd3, 32'h5555_AAAA);
    exp_regs[3*32 +: 32] = 32'h5555_AAAA;
    chk("set3b_old",  256'(cfg_wdata_1), 256'(32'hDEAD_BEEF));
    chk("set3b_regs", cfg_regs, exp_regs);

    // Out of range
    run_cmd("set8", 8'h43, 32'd8, 32'd1);
    chk("set8_err",  256'(cfg_error), 256'(1'b1));
    chk("set8_w0",   256'(cfg_wdata_0), 256'(32'd8));
    chk("set8_regs", cfg_regs, exp_regs);
    run_cmd("getff", 8'h63, 32'hFFFF_FFFF, 32'h0);
    chk("getff_err", 256'(cfg_error), 256'(1'b1));
    chk("getff_w1",  256'(cfg_wdata_1), 256'(32'd0));
    chk("getff_w0",  256'(cfg_wdata_0), 256'(32'hFFFF_FFFF));
    run_cmd("set100", 8'h43, 32'h0000_0100, 32'h9999_9999);
    chk("set100_err",  256'(cfg_error), 256'(1'b1));
    chk("set100_regs", cfg_regs, exp_regs);

    // cpu_ack while idle is ignored; results held
    cpu_ack = 1'b1; cpu_error = 1'b0; cpu_result_0 = 32'hBAD0; cpu_result_1 = 32'hBAD1;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cfg_done) dones++;
    end
    cpu_ack = 1'b0;
    chk("idleack_dones", 256'(dones), 256'(0));
    chk("idleack_w0",    256'(cfg_wdata_0), 256'(32'h0000_0100));
    chk("idleack_err",   256'(cfg_error), 256'(1'b1));

    // Forward to CPU, ack after 10 cycles
    cfg_pending = 1'b1; cfg_cmd = 8'h55; cfg_rdata_0 = 32'h11; cfg_rdata_1 = 32'h22;
    tick(); tick();
    chk("fwd_req",  256'(cpu_req), 256'(1'b1));
    chk("fwd_cmd",  256'(cpu_cmd), 256'(8'h55));
    chk("fwd_args", 256'({cpu_arg_0, cpu_arg_1}), 256'({32'h11, 32'h22}));
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cfg_done) dones++;
    end
    chk("fwd_wait_dones", 256'(dones), 256'(0));
    chk("fwd_wait_req",   256'(cpu_req), 256'(1'b1));
    chk("fwd_wait_w0",    256'(cfg_wdata_0), 256'(32'h0000_0100));
    cpu_ack = 1'b1; cpu_error = 1'b1; cpu_result_0 = 32'h1234; cpu_result_1 = 32'h5678;
    tick();
    cpu_ack = 1'b0; cpu_error = 1'b0;
    chk("fwd_done", 256'(cfg_done), 256'(1'b1));
    chk("fwd_req0", 256'(cpu_req), 256'(1'b0));
    chk("fwd_w",    256'({cfg_wdata_0, cfg_wdata_1}), 256'({32'h1234, 32'h5678}));
    chk("fwd_err",  256'(cfg_error), 256'(1'b1));
    cfg_pending = 1'b0;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cfg_done) dones++;
    end
    chk("fwd_single_done", 256'(dones), 256'(0));

    // Back-to-back: pending held through HOLD, second command follows
    cfg_pending = 1'b1; cfg_cmd = 8'h63; cfg_rdata_0 = 32'd7; cfg_rdata_1 = 32'd0;
    dones = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (cfg_done) dones++;
      if (i == 2) begin
        chk("b2b_first_w1", 256'(cfg_wdata_1), 256'(32'h0102_0304));
        cfg_cmd = 8'h43; cfg_rdata_0 = 32'd5; cfg_rdata_1 = 32'hCAFE_F00D;
      end
      if (i == 6) begin
        chk("b2b_second_done", 256'(cfg_done), 256'(1'b1));
        cfg_pending = 1'b0;
      end
    end
    exp_regs[5*32 +: 32] = 32'hCAFE_F00D;
    chk("b2b_dones", 256'(dones), 256'(2));
    chk("b2b_regs",  cfg_regs, exp_regs);
    chk("b2b_w1",    256'(cfg_wdata_1), 256'(32'd0));

    // Reset mid-FORWARD
    cfg_pending = 1'b1; cfg_cmd = 8'hA0; cfg_rdata_0 = 32'h1; cfg_rdata_1 = 32'h2;
    tick(); tick(); tick();
    chk("abort_req_before", 256'(cpu_req), 256'(1'b1));
    cfg_pending = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_req_async", 256'(cpu_req), 256'(1'b0));
    chk("abort_regs",      cfg_regs, 256'd0);
    tick();
    reset = 1'b0;
    cpu_ack = 1'b1; cpu_result_0 = 32'hEEEE;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cfg_done) dones++;
    end
    cpu_ack = 1'b0;
    chk("abort_dones", 256'(dones), 256'(0));
    chk("abort_w0",    256'(cfg_wdata_0), 256'(32'd0));

    // First command after reset runs normally
    run_cmd("post_rst", 8'h76, 32'h0, 32'h0);
    chk("post_rst_w0", 256'(cfg_wdata_0), 256'(32'h5343_7632));

    // Interrupt: single pulse, then a 3-cycle request
    cpu_irq_req = 1'b1;
    #2;
    chk("irq_not_yet", 256'(cfg_irq), 256'(1'b0));
    tick();
    cpu_irq_req = 1'b0;
    chk("irq_pulse_hi", 256'(cfg_irq), 256'(1'b1));
    tick();
    chk("irq_pulse_lo", 256'(cfg_irq), 256'(1'b0));
    cpu_irq_req = 1'b1;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cfg_irq) dones++;
    end
    cpu_irq_req = 1'b0;
    tick();
    chk("irq_k3_count", 256'(dones), 256'(3));
    chk("irq_k3_end",   256'(cfg_irq), 256'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
